wb_arbiter: RTL and testbench

- Producer side of the integer register file's single write port (A3/WD3/WE3).
- Merges the in-order pipeline writeback with results from a variable-latency unit (load/div) that uses a valid/ready handshake.
- Buffers unit results in a small FIFO.
- Keeps a per-register pending scoreboard that decode uses to stall on unresolved long-latency destinations.

---
 rtl/wb_arbiter_pkg.sv | 15 +
 rtl/wb_fifo.sv | 62 ++++++
 rtl/wb_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_arbiter_pkg;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned NREG  = 32;
   localparam int unsigned REG_W = $clog2(NREG);

   localparam logic [REG_W-1:0] REG_X0 = '0;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  wd;
   } wr_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered long-latency results; DEPTH must be a power of two >= 2.
module wb_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_en, pop_en;

   assign push_en = push && (count_q != FULL_CNT);
   assign pop_en  = pop && (count_q != '0);

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_en) wptr_d = wptr_q + 1'b1;
      if (pop_en)  rptr_d = rptr_q + 1'b1;
      if (push_en && !pop_en) begin
         count_d = count_q + 1'b1;
      end else if (!push_en && pop_en) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem_q[wptr_q] <= wdata;
   end

   assign rdata = mem_q[rptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback over buffered long-latency results,
// plus the pending-destination scoreboard. Define WB_BYPASS_EN to let results skip an empty FIFO.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pipe_we,
   input  logic [REG_W-1:0] pipe_rd,
   input  logic [XLEN-1:0]  pipe_wd,
   input  logic             lu_valid,
   input  logic [REG_W-1:0] lu_rd,
   input  logic [XLEN-1:0]  lu_wd,
   output logic             lu_ready,
   input  logic             iss_valid,
   input  logic [REG_W-1:0] iss_rd,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   output logic             rs1_busy,
   output logic             rs2_busy,
   output logic             rf_we,
   output logic [REG_W-1:0] rf_a3,
   output logic [XLEN-1:0]  rf_wd
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [6:0] STARVE_LIM = 7'd64;

   logic             pipe_act, lu_acc, lu_nz, push, pop, bypass;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   wr_req_t          fifo_head, lu_req;

   logic             rf_we_q, rf_we_d;
   logic [REG_W-1:0] rf_a3_q, rf_a3_d;
   logic [XLEN-1:0]  rf_wd_q, rf_wd_d;
   logic [NREG-1:0]  busy_q, busy_d;
   logic [6:0]       starve_q, starve_d;

   assign lu_ready = !rst && (fifo_count < DEPTH_CNT);
   assign pipe_act = pipe_we && (pipe_rd != REG_X0);
   assign lu_acc   = lu_valid && lu_ready;
   assign lu_nz    = (lu_rd != REG_X0);
   assign lu_req   = '{rd: lu_rd, wd: lu_wd};

`ifdef WB_BYPASS_EN
   assign bypass = !pipe_act && fifo_empty && lu_acc && lu_nz;
`else
   assign bypass = 1'b0;
`endif

   // Results to x0 complete the handshake but are dropped here.
   assign push = lu_acc && lu_nz && !bypass;
   assign pop  = !pipe_act && !fifo_empty;

   wb_fifo #(
      .WIDTH ($bits(wr_req_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (lu_req),
      .pop   (pop),
      .rdata (fifo_head),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   always_comb begin
      rf_we_d = 1'b0;
      rf_a3_d = rf_a3_q;
      rf_wd_d = rf_wd_q;
      if (pipe_act) begin
         rf_we_d = 1'b1;
         rf_a3_d = pipe_rd;
         rf_wd_d = pipe_wd;
      end else if (pop) begin
         rf_we_d = 1'b1;
         rf_a3_d = fifo_head.rd;
         rf_wd_d = fifo_head.wd;
      end else if (bypass) begin
         rf_we_d = 1'b1;
         rf_a3_d = lu_rd;
         rf_wd_d = lu_wd;
      end
   end

   // Clears first so a same-cycle issue to the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (pop)    busy_d[fifo_head.rd] = 1'b0;
      if (bypass) busy_d[lu_rd] = 1'b0;
      if (iss_valid && (iss_rd != REG_X0)) busy_d[iss_rd] = 1'b1;
      busy_d[REG_X0] = 1'b0;
   end

   // Cycles the FIFO head has waited behind pipeline writes; decode must leave gaps.
   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (starve_q != '1) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q  <= 1'b0;
         rf_a3_q  <= '0;
         rf_wd_q  <= '0;
         busy_q   <= '0;
         starve_q <= '0;
      end else begin
         rf_we_q  <= rf_we_d;
         rf_a3_q  <= rf_a3_d;
         rf_wd_q  <= rf_wd_d;
         busy_q   <= busy_d;
         starve_q <= starve_d;
         assert (starve_q < STARVE_LIM);
      end
   end

   assign rs1_busy = (rs1 != REG_X0) && busy_q[rs1];
   assign rs2_busy = (rs2 != REG_X0) && busy_q[rs2];
   assign rf_we    = rf_we_q;
   assign rf_a3    = rf_a3_q;
   assign rf_wd    = rf_wd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   logic             clk, rst;
   logic             pipe_we, lu_valid, lu_ready, iss_valid;
   logic [4:0]       pipe_rd, lu_rd, iss_rd, rs1, rs2;
   logic [63:0]      pipe_wd, lu_wd;
   logic             rs1_busy, rs2_busy, rf_we;
   logic [4:0]       rf_a3;
   logic [63:0]      rf_wd;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        pipe_we;
      logic [4:0]  pipe_rd;
      logic [63:0] pipe_wd;
      logic        lu_valid;
      logic [4:0]  lu_rd;
      logic [63:0] lu_wd;
      logic        iss_valid;
      logic [4:0]  iss_rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        e_we;
      logic [4:0]  e_a3;
      logic [63:0] e_wd;
      logic        e_rdy;
      logic        e_b1;
      logic        e_b2;
   } vec_t;

   vec_t vecs[8];

   wb_arbiter #(.FIFO_DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .pipe_we   (pipe_we),
      .pipe_rd   (pipe_rd),
      .pipe_wd   (pipe_wd),
      .lu_valid  (lu_valid),
      .lu_rd     (lu_rd),
      .lu_wd     (lu_wd),
      .lu_ready  (lu_ready),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .rs1_busy  (rs1_busy),
      .rs2_busy  (rs2_busy),
      .rf_we     (rf_we),
      .rf_a3     (rf_a3),
      .rf_wd     (rf_wd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required $finish before 100000");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic chk_rf(input string nm, input logic we, input logic [4:0] a3,
                         input logic [63:0] wd);
      chk({nm, "_we"}, rf_we, we);
      if (we) begin
         chk({nm, "_a3"}, rf_a3, a3);
         chk({nm, "_wd"}, rf_wd, wd);
      end
   endtask

   task automatic idle();
      pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
      lu_valid = 0; lu_rd = 0; lu_wd = 0;
      iss_valid = 0; iss_rd = 0;
   endtask

   task automatic drv_pipe(input logic [4:0] rd, input logic [63:0] wd);
      pipe_we = 1; pipe_rd = rd; pipe_wd = wd;
   endtask

   task automatic drv_lu(input logic [4:0] rd, input logic [63:0] wd);
      lu_valid = 1; lu_rd = rd; lu_wd = wd;
   endtask

   initial begin
      // pipe_we rd rd_wd | lu_v rd wd | iss rd | rs1 rs2 | we a3 wd | rdy b1 b2
      vecs[0] = '{1, 5'd5, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0,
                  1, 5'd5, 64'hDEAD_BEEF, 1, 0, 0};
      vecs[1] = '{1, 5'd0, 64'h1111, 0, 0, 0, 0, 0, 0, 0,
                  0, 5'd5, 64'hDEAD_BEEF, 1, 0, 0};
      vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  0, 5'd5, 64'hDEAD_BEEF, 1, 0, 0};
      vecs[3] = '{1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 0, 0,
                  1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0};
      vecs[4] = '{0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0,
                  0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0};
      vecs[5] = '{1, 5'd9, 64'h99, 0, 0, 0, 1, 5'd0, 5'd0, 5'd9,
                  1, 5'd9, 64'h99, 1, 0, 1};
      vecs[6] = '{0, 0, 0, 1, 5'd0, 64'hABC, 0, 0, 5'd9, 5'd0,
                  0, 5'd9, 64'h99, 1, 1, 0};
      vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9,
                  0, 5'd9, 64'h99, 1, 1, 1};

      // Reset
      idle();
      rst = 1; rs1 = 0; rs2 = 0;
      tick();
      tick();
      chk("rst_we", rf_we, 0);
      chk("rst_a3", rf_a3, 0);
      chk("rst_wd", rf_wd, 0);
      chk("rst_rdy", lu_ready, 0);
      rst = 0;
      #1;
      chk("post_rst_rdy", lu_ready, 1);
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         #1;
         chk($sformatf("post_rst_b1_%0d", i), rs1_busy, 0);
         chk($sformatf("post_rst_b2_%0d", i), rs2_busy, 0);
      end

      // Vector table: a rf value is held when e_we is 0, so a3/wd are always compared
      for (int i = 0; i < 8; i++) begin
         pipe_we = vecs[i].pipe_we; pipe_rd = vecs[i].pipe_rd; pipe_wd = vecs[i].pipe_wd;
         lu_valid = vecs[i].lu_valid; lu_rd = vecs[i].lu_rd; lu_wd = vecs[i].lu_wd;
         iss_valid = vecs[i].iss_valid; iss_rd = vecs[i].iss_rd;
         rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
         tick();
         chk($sformatf("vec%0d_we", i), rf_we, vecs[i].e_we);
         chk($sformatf("vec%0d_a3", i), rf_a3, vecs[i].e_a3);
         chk($sformatf("vec%0d_wd", i), rf_wd, vecs[i].e_wd);
         chk($sformatf("vec%0d_rdy", i), lu_ready, vecs[i].e_rdy);
         chk($sformatf("vec%0d_b1", i), rs1_busy, vecs[i].e_b1);
         chk($sformatf("vec%0d_b2", i), rs2_busy, vecs[i].e_b2);
      end

      // Issue rd=7 then its long-latency result with the pipeline idle
      idle(); rs1 = 7; rs2 = 0;
      iss_valid = 1; iss_rd = 7;
      tick();
      chk("a_set", rs1_busy, 1);
      iss_valid = 0;
      chk("a_rdy", lu_ready, 1);
      drv_lu(7, 64'h1234);
      tick();
      idle();
`ifdef WB_BYPASS_EN
      chk_rf("a_byp", 1, 7, 64'h1234);
      chk("a_byp_busy", rs1_busy, 0);
      tick();
      chk_rf("a_after", 0, 0, 0);
      chk("a_after_busy", rs1_busy, 0);
`else
      chk_rf("a_acc", 0, 0, 0);
      chk("a_acc_busy", rs1_busy, 1);
      tick();
      chk_rf("a_pop", 1, 7, 64'h1234);
      chk("a_pop_busy", rs1_busy, 0);
      tick();
      chk_rf("a_after", 0, 0, 0);
      chk("a_after_busy", rs1_busy, 0);
`endif

      // Two results buffered behind three pipeline writes
      drv_pipe(10, 64'hA0); drv_lu(3, 64'h33);
      tick();
      chk_rf("b0", 1, 10, 64'hA0);
      chk("b0_rdy", lu_ready, 1);
      drv_pipe(11, 64'hA1); drv_lu(4, 64'h44);
      tick();
      chk_rf("b1", 1, 11, 64'hA1);
      chk("b1_rdy", lu_ready, 0);
      idle(); drv_pipe(12, 64'hA2);
      tick();
      chk_rf("b2", 1, 12, 64'hA2);
      chk("b2_rdy", lu_ready, 0);
      idle();
      tick();
      chk_rf("b3", 1, 3, 64'h33);
      chk("b3_rdy", lu_ready, 1);
      tick();
      chk_rf("b4", 1, 4, 64'h44);
      chk("b4_rdy", lu_ready, 1);
      tick();
      chk_rf("b5", 0, 0, 0);

      // busy[9] is still set from the table; pop to 9 coincides with a new issue to 9
      rs1 = 9;
      drv_pipe(1, 64'h1); drv_lu(9, 64'h9);
      tick();
      chk_rf("c0", 1, 1, 64'h1);
      idle(); iss_valid = 1; iss_rd = 9;
      tick();
      chk_rf("c1", 1, 9, 64'h9);
      chk("c1_setwins", rs1_busy, 1);
      idle();
      tick();
      chk_rf("c2", 0, 0, 0);
      chk("c2_busy", rs1_busy, 1);
      drv_pipe(2, 64'h2); drv_lu(9, 64'h19);
      tick();
      idle();
      tick();
      chk_rf("c4", 1, 9, 64'h19);
      chk("c4_clear", rs1_busy, 0);

      // Reset with two entries buffered and busy[3] set
      idle(); rs1 = 3; rs2 = 4;
      iss_valid = 1; iss_rd = 3;
      tick();
      chk("d_set", rs1_busy, 1);
      idle(); drv_pipe(1, 64'h5); drv_lu(3, 64'hD3);
      tick();
      idle(); drv_pipe(2, 64'h6); drv_lu(4, 64'hD4);
      tick();
      chk("d_full", lu_ready, 0);
      idle();
      rst = 1;
      tick();
      chk("d_rst_we", rf_we, 0);
      chk("d_rst_a3", rf_a3, 0);
      chk("d_rst_wd", rf_wd, 0);
      chk("d_rst_rdy", lu_ready, 0);
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("d_post%0d_we", i), rf_we, 0);
         chk($sformatf("d_post%0d_b1", i), rs1_busy, 0);
         chk($sformatf("d_post%0d_b2", i), rs2_busy, 0);
         chk($sformatf("d_post%0d_rdy", i), lu_ready, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
